alu_pkt_rx: RTL and testbench

//  Packet receive/framing stage directly upstream of the ALU execution core inside alu_top.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_op_buffer.sv | 36 +++
 rtl/alu_pkt_rx.sv | 155 +++++++++++++++
 tb/tb_alu_pkt_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU packet path: bus/buffer sizing, header
// field positions and the receive-FSM state type.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_BUS_WIDTH   = 16;
    localparam int ALU_BUFFER_SIZE = 64;
    localparam int CNT_WIDTH       = 6;

    // Header layout: payload count in the low bits, opcode above it.
    localparam int HDR_CNT_LSB = 0;
    localparam int HDR_CNT_MSB = CNT_WIDTH - 1;
    localparam int HDR_OP_LSB  = CNT_WIDTH;
    localparam int HDR_OP_MSB  = ALU_BUS_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } rx_state_t;

endpackage : alu_pkg

// File: rtl/alu_op_buffer.sv
// ---------------------------------------------------------------------------
// alu_op_buffer
// Operand register file: one synchronous write port, one asynchronous read
// port. Storage is deliberately not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  mem[raddr], combinational
// ---------------------------------------------------------------------------
module alu_op_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : alu_op_buffer

// File: rtl/alu_pkt_rx.sv
// ---------------------------------------------------------------------------
// alu_pkt_rx
// Packet receive/framing stage in front of the ALU execution core. Accepts
// one header beat followed by header[CNT_WIDTH-1:0] payload beats, stores
// payloads in the operand buffer and holds the complete packet until the
// core releases it with pkt_done. Flags framing and overrun errors.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   data_in/valid_in/cmd_in  input stream (cmd_in=1 marks a header beat)
//   pkt_ready            complete packet held
//   hdr_out, nof_ops     latched header and its payload count
//   rd_addr, rd_data     operand read port (0 beyond nof_ops)
//   pkt_done             core has consumed the packet
//   busy                 collecting or holding a packet
//   err_frame            1-cycle pulse: stray payload or premature header
//   err_overrun          1-cycle pulse: beat while a packet is held
// ---------------------------------------------------------------------------
module alu_pkt_rx #(
    parameter int DATA_WIDTH = alu_pkg::ALU_BUS_WIDTH,
    parameter int BUF_DEPTH  = alu_pkg::ALU_BUFFER_SIZE,
    parameter int CNT_WIDTH  = alu_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  cmd_in,
    output logic                  pkt_ready,
    output logic [DATA_WIDTH-1:0] hdr_out,
    output logic [CNT_WIDTH-1:0]  nof_ops,
    input  logic [CNT_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  pkt_done,
    output logic                  busy,
    output logic                  err_frame,
    output logic                  err_overrun
);

    import alu_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    rx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic                  err_frame_q, err_frame_d;
    logic                  err_overrun_q, err_overrun_d;
    logic                  accept_hdr;
    logic                  buf_we;
    logic                  hdr_beat;
    logic                  pay_beat;
    logic [DATA_WIDTH-1:0] buf_rdata;

    assign hdr_beat = valid_in & cmd_in;
    assign pay_beat = valid_in & ~cmd_in;

    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        err_frame_d   = 1'b0;
        err_overrun_d = 1'b0;
        accept_hdr    = 1'b0;
        buf_we        = 1'b0;

        case (state_q)
            IDLE: begin
                if (hdr_beat) begin
                    accept_hdr = 1'b1;
                end else if (pay_beat) begin
                    err_frame_d = 1'b1;
                end
            end
            COLLECT: begin
                if (hdr_beat) begin
                    // New header before the old packet finished: restart on it.
                    err_frame_d = 1'b1;
                    accept_hdr  = 1'b1;
                end else if (pay_beat) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + CNT_ONE;
                    // cnt_q is never 0 here, so cnt_q-1 is the last index.
                    if (wr_ptr_q == cnt_q - CNT_ONE) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (pkt_done) begin
                    // Release and treat this cycle's beat as if already idle,
                    // so a following header needs no bubble.
                    state_d = IDLE;
                    if (hdr_beat) begin
                        accept_hdr = 1'b1;
                    end else if (pay_beat) begin
                        err_frame_d = 1'b1;
                    end
                end else if (valid_in) begin
                    err_overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_hdr) begin
            hdr_d    = data_in;
            cnt_d    = data_in[CNT_WIDTH-1:0];
            wr_ptr_d = '0;
            state_d  = (data_in[CNT_WIDTH-1:0] == '0) ? READY : COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hdr_q         <= '0;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    alu_op_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .ADDR_WIDTH (CNT_WIDTH)
    ) u_op_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_addr),
        .rdata (buf_rdata)
    );

    // State-derived outputs follow the async reset immediately.
    assign pkt_ready   = (state_q == READY);
    assign busy        = (state_q != IDLE);
    assign hdr_out     = hdr_q;
    assign nof_ops     = cnt_q;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;
    assign rd_data     = (rd_addr < cnt_q) ? buf_rdata : '0;

endmodule : alu_pkt_rx

// File: tb/tb_alu_pkt_rx.sv
// ---------------------------------------------------------------------------
// tb_alu_pkt_rx
// Self-checking bench for alu_pkt_rx: directed scenarios plus a randomized
// run checked against a packet-level reference model.
// ---------------------------------------------------------------------------
module tb_alu_pkt_rx;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic [15:0] data_in  = '0;
    logic        valid_in = 1'b0;
    logic        cmd_in   = 1'b0;
    logic [5:0]  rd_addr  = '0;
    logic        pkt_done = 1'b0;
    logic        pkt_ready;
    logic [15:0] hdr_out;
    logic [5:0]  nof_ops;
    logic [15:0] rd_data;
    logic        busy;
    logic        err_frame;
    logic        err_overrun;

    int n_vec = 0;
    int n_err = 0;

    alu_pkt_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .cmd_in      (cmd_in),
        .pkt_ready   (pkt_ready),
        .hdr_out     (hdr_out),
        .nof_ops     (nof_ops),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pkt_done    (pkt_done),
        .busy        (busy),
        .err_frame   (err_frame),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic beat(input logic v, input logic c, input logic [15:0] d, input logic done);
        valid_in = v;
        cmd_in   = c;
        data_in  = d;
        pkt_done = done;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        cmd_in   = 1'b0;
        pkt_done = 1'b0;
        data_in  = 16'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (pkt_ready !== 1'b0) begin n_err++; $display("FAIL reset_pkt_ready got=%b exp=0", pkt_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (hdr_out !== 16'h0) begin n_err++; $display("FAIL reset_hdr got=%h exp=0000", hdr_out); end
        n_vec++; if (nof_ops !== 6'd0) begin n_err++; $display("FAIL reset_nof_ops got=%0d exp=0", nof_ops); end
        n_vec++; if ({err_frame, err_overrun} !== 2'b00) begin n_err++; $display("FAIL reset_err got=%b exp=00", {err_frame, err_overrun}); end
        rst_n = 1'b1;
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_basic();
        beat(1, 1, 16'h0043, 0);
        n_vec++; if (busy !== 1'b1 || pkt_ready !== 1'b0) begin n_err++; $display("FAIL basic_hdr busy=%b ready=%b exp busy=1 ready=0", busy, pkt_ready); end
        n_vec++; if (nof_ops !== 6'd3) begin n_err++; $display("FAIL basic_nof_ops got=%0d exp=3", nof_ops); end
        beat(1, 0, 16'h0001, 0);
        beat(1, 0, 16'h0002, 0);
        n_vec++; if (pkt_ready !== 1'b0) begin n_err++; $display("FAIL basic_early_ready got=%b exp=0", pkt_ready); end
        beat(1, 0, 16'h0003, 0);
        n_vec++; if (pkt_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready got=%b exp=1", pkt_ready); end
        rd_addr = 6'd2; #1;
        n_vec++; if (rd_data !== 16'h0003) begin n_err++; $display("FAIL basic_rd2 got=%h exp=0003", rd_data); end
        rd_addr = 6'd3; #1;
        n_vec++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL basic_rd3 got=%h exp=0000", rd_data); end
        beat(0, 0, 16'h0, 1);
        n_vec++; if (pkt_ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_release ready=%b busy=%b exp 0 0", pkt_ready, busy); end
        beat(1, 0, 16'hDEAD, 0);
        n_vec++; if (err_frame !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL basic_stray err_frame=%b busy=%b exp 1 0", err_frame, busy); end
        beat(0, 0, 16'h0, 0);
        n_vec++; if (err_frame !== 1'b0) begin n_err++; $display("FAIL basic_stray_pulse got=%b exp=0", err_frame); end
        $display("test_basic: 3-payload packet and stray beat");
    endtask

    task automatic test_zero_count();
        beat(1, 1, 16'h0080, 0);
        n_vec++; if (pkt_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready got=%b exp=1", pkt_ready); end
        n_vec++; if (nof_ops !== 6'd0 || hdr_out !== 16'h0080) begin n_err++; $display("FAIL zero_hdr nof=%0d hdr=%h exp 0 0080", nof_ops, hdr_out); end
        rd_addr = 6'd0; #1;
        n_vec++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL zero_rd0 got=%h exp=0000", rd_data); end
        beat(0, 0, 16'h0, 1);
        $display("test_zero_count: empty packet");
    endtask

    task automatic test_frame_error();
        int fe_cnt = 0;
        beat(1, 1, 16'h0042, 0); fe_cnt += int'(err_frame);
        beat(1, 0, 16'h00AA, 0); fe_cnt += int'(err_frame);
        beat(1, 1, 16'h0041, 0); fe_cnt += int'(err_frame);
        n_vec++; if (err_frame !== 1'b1 || pkt_ready !== 1'b0) begin n_err++; $display("FAIL frame_pulse err=%b ready=%b exp 1 0", err_frame, pkt_ready); end
        beat(1, 0, 16'h0055, 0); fe_cnt += int'(err_frame);
        n_vec++; if (fe_cnt != 1) begin n_err++; $display("FAIL frame_count got=%0d exp=1", fe_cnt); end
        n_vec++; if (pkt_ready !== 1'b1 || hdr_out !== 16'h0041) begin n_err++; $display("FAIL frame_final ready=%b hdr=%h exp 1 0041", pkt_ready, hdr_out); end
        rd_addr = 6'd0; #1;
        n_vec++; if (rd_data !== 16'h0055) begin n_err++; $display("FAIL frame_rd0 got=%h exp=0055", rd_data); end
        $display("test_frame_error: premature header abandoned");
    endtask

    // Starts from the packet left held by test_frame_error.
    task automatic test_back_to_back();
        beat(1, 0, 16'h1234, 0);
        n_vec++; if (err_overrun !== 1'b1 || pkt_ready !== 1'b1) begin n_err++; $display("FAIL ovr_pulse ovr=%b ready=%b exp 1 1", err_overrun, pkt_ready); end
        rd_addr = 6'd0; #1;
        n_vec++; if (rd_data !== 16'h0055) begin n_err++; $display("FAIL ovr_buf got=%h exp=0055", rd_data); end
        beat(0, 0, 16'h0, 0);
        n_vec++; if (err_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_one_cycle got=%b exp=0", err_overrun); end
        beat(1, 1, 16'h0041, 1);
        n_vec++; if (pkt_ready !== 1'b0 || busy !== 1'b1 || err_frame !== 1'b0 || err_overrun !== 1'b0) begin
            n_err++; $display("FAIL b2b_accept ready=%b busy=%b fe=%b ov=%b exp 0 1 0 0", pkt_ready, busy, err_frame, err_overrun); end
        beat(1, 0, 16'h0077, 0);
        rd_addr = 6'd0; #1;
        n_vec++; if (pkt_ready !== 1'b1 || rd_data !== 16'h0077) begin n_err++; $display("FAIL b2b_packet ready=%b rd0=%h exp 1 0077", pkt_ready, rd_data); end
        beat(0, 0, 16'h0, 1);
        beat(1, 1, 16'h0080, 0);
        beat(1, 0, 16'h1111, 1);
        n_vec++; if (err_frame !== 1'b1 || busy !== 1'b0 || err_overrun !== 1'b0) begin n_err++; $display("FAIL done_stray fe=%b busy=%b ov=%b exp 1 0 0", err_frame, busy, err_overrun); end
        $display("test_back_to_back: overrun and release with header");
    endtask

    task automatic test_long_gaps();
        logic [15:0] pay [63];
        int early = 0;
        beat(1, 1, 16'h003F, 0);
        for (int i = 0; i < 63; i++) begin
            repeat ($urandom_range(0, 2)) beat(0, 1'($urandom), 16'($urandom), 0);
            pay[i] = 16'($urandom);
            beat(1, 0, pay[i], 0);
            if (i < 62) early += int'(pkt_ready);
        end
        n_vec++; if (early != 0) begin n_err++; $display("FAIL long_early_ready got=%0d exp=0", early); end
        n_vec++; if (pkt_ready !== 1'b1 || nof_ops !== 6'd63) begin n_err++; $display("FAIL long_ready ready=%b nof=%0d exp 1 63", pkt_ready, nof_ops); end
        for (int i = 0; i < 63; i++) begin
            rd_addr = 6'(i); #1;
            n_vec++; if (rd_data !== pay[i]) begin n_err++; $display("FAIL long_rd[%0d] got=%h exp=%h", i, rd_data, pay[i]); end
        end
        rd_addr = 6'd63; #1;
        n_vec++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL long_rd63 got=%h exp=0000", rd_data); end
        beat(0, 0, 16'h0, 1);
        $display("test_long_gaps: 63 payloads with gaps");
    endtask

    task automatic test_reset_mid();
        beat(1, 1, 16'h0005, 0);
        beat(1, 0, 16'h0101, 0);
        beat(1, 0, 16'h0202, 0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || pkt_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_state busy=%b ready=%b exp 0 0", busy, pkt_ready); end
        n_vec++; if (hdr_out !== 16'h0 || nof_ops !== 6'd0) begin n_err++; $display("FAIL rstmid_hdr hdr=%h nof=%0d exp 0000 0", hdr_out, nof_ops); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        beat(1, 1, 16'h0001, 0);
        beat(1, 0, 16'hBEEF, 0);
        rd_addr = 6'd0; #1;
        n_vec++; if (pkt_ready !== 1'b1 || rd_data !== 16'hBEEF || hdr_out !== 16'h0001) begin
            n_err++; $display("FAIL rstmid_fresh ready=%b rd0=%h hdr=%h exp 1 beef 0001", pkt_ready, rd_data, hdr_out); end
        beat(0, 0, 16'h0, 1);
        $display("test_reset_mid: async reset and recovery");
    endtask

    // Reference model at packet level: an open packet collecting payloads,
    // and a held packet waiting for release.
    task automatic test_random();
        logic [15:0] m_hdr;
        logic        m_open;
        logic        m_held;
        logic [15:0] m_pay [$];
        logic        v, c, dn, efe, eov;
        logic [15:0] d, exp_rd;
        int          a;
        do_reset();
        m_hdr = '0; m_open = 1'b0; m_held = 1'b0; m_pay.delete();
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 9) < 7);
            c  = ($urandom_range(0, 3) == 0);
            dn = ($urandom_range(0, 2) == 0);
            d  = c ? {10'($urandom), 6'($urandom_range(0, 3))} : 16'($urandom);
            efe = 1'b0; eov = 1'b0;
            if (m_held) begin
                if (dn) m_held = 1'b0;
                else if (v) eov = 1'b1;
            end
            if (v && !m_held) begin
                if (c) begin
                    efe = m_open; m_hdr = d; m_pay.delete(); m_open = 1'b1;
                end else if (m_open) begin
                    m_pay.push_back(d);
                end else begin
                    efe = 1'b1;
                end
                if (m_open && m_pay.size() == int'(m_hdr[5:0])) begin
                    m_open = 1'b0; m_held = 1'b1;
                end
            end
            beat(v, c, d, dn);
            n_vec++; if (pkt_ready !== m_held || busy !== (m_open | m_held)) begin
                n_err++; $display("FAIL rnd_state[%0d] ready=%b busy=%b exp %b %b", i, pkt_ready, busy, m_held, m_open | m_held); end
            n_vec++; if (err_frame !== efe || err_overrun !== eov) begin
                n_err++; $display("FAIL rnd_err[%0d] fe=%b ov=%b exp %b %b", i, err_frame, err_overrun, efe, eov); end
            n_vec++; if (hdr_out !== m_hdr || nof_ops !== m_hdr[5:0]) begin
                n_err++; $display("FAIL rnd_hdr[%0d] hdr=%h nof=%0d exp %h %0d", i, hdr_out, nof_ops, m_hdr, m_hdr[5:0]); end
            if (m_held) begin
                a = $urandom_range(0, 4);
                rd_addr = 6'(a); #1;
                exp_rd = (a < m_pay.size()) ? m_pay[a] : 16'h0;
                n_vec++; if (rd_data !== exp_rd) begin n_err++; $display("FAIL rnd_rd[%0d] addr=%0d got=%h exp=%h", i, a, rd_data, exp_rd); end
            end
        end
        $display("test_random: 400 random beats");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_frame_error();
        test_back_to_back();
        test_long_gaps();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_alu_pkt_rx
